ctrl_bundle_pipe: RTL
=====================

# ctrl_bundle_pipe

Downstream consumer of the 4-bit ID-stage control bundle: registers the bundle through the ID/EX, EX/MEM and MEM/WB pipeline boundaries, unpacks it into per-stage enables, and decodes the ALU operation in EX. It inserts bubbles on stall and flush, and keeps a saturating bubble counter and a sticky illegal-ALU-op flag. It sits between the ID-stage control packer and the EX/MEM/WB datapaths of the MIPS pipeline.

## Interface
- BCNT_W, 8, width of the saturating bubble counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- controlSig  in  4  ID bundle: [3:2]=ALUOp, [1]=WBSig (register write enable), [0]=MEMSig (memory write enable)
- funct  in  6  instruction funct field, ID stage, aligned with controlSig
- stall  in  1  load-use stall: bubble into ID/EX
- flush  in  1  branch flush: bubble into ID/EX and EX/MEM
- ex_valid  out  1  EX stage holds a real instruction
- ex_alu_ctrl  out  4  decoded ALU control, EX stage
- ex_illegal  out  1  EX valid and decode illegal (combinational from EX regs)
- mem_we  out  1  memory write enable, MEM stage
- mem_wb_pending  out  1  WBSig carried in MEM stage (forwarding qualifier)
- wb_reg_we  out  1  register write enable, WB stage
- bubble_cnt  out  BCNT_W  bubbles inserted since reset, saturating
- err_sticky  out  1  set when ex_illegal was ever 1 since reset

## Operation
- Stage registers:
  - ID/EX: {valid, ALUOp, WB, MEM, funct}
  - EX/MEM: {valid, WB, MEM}
  - MEM/WB: {valid, WB}
- Bubble: all fields 0. A bubble never asserts mem_we, mem_wb_pending or wb_reg_we.
- Per-edge update, in priority order:
  - flush=1: ID/EX and EX/MEM load bubbles; MEM/WB loads EX/MEM's current contents. Flush overrides stall.
  - stall=1, flush=0: ID/EX loads a bubble; EX/MEM and MEM/WB advance normally. The ID stage itself is held externally.
  - Otherwise all three stages advance. ID/EX.valid loads 1.
- Outputs:
  - mem_we = EX/MEM.valid & EX/MEM.MEM
  - mem_wb_pending = EX/MEM.valid & EX/MEM.WB
  - wb_reg_we = MEM/WB.valid & MEM/WB.WB
- ALU decode from ID/EX registers, combinational:
  - ALUOp 00 -> 0010 (add)
  - ALUOp 01 -> 0110 (sub)
  - ALUOp 10 -> by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, other -> 1111
  - ALUOp 11 -> 1111
- ex_illegal = ex_valid & (ex_alu_ctrl==4'b1111). When ex_valid=0, ex_alu_ctrl is forced to 0000.
- bubble_cnt increments by 1 on each edge where stall|flush=1. It holds at 2^BCNT_W-1. A simultaneous stall and flush counts once.
- err_sticky sets on the edge after ex_illegal=1. It clears only on reset.

## Timing
- Reset (async assert, any time, including mid-stall): all stage registers, bubble_cnt and err_sticky go to 0 immediately, so every output is 0. The pipeline refills from empty after deassertion; no in-flight control survives.
- Reset deassertion is synchronised externally; the first capture occurs on the first rising edge with rst_n=1.
- Latency from a bundle presented at ID in cycle N (stall=flush=0):
  - ex_* valid in cycle N+1
  - mem_we / mem_wb_pending in N+2
  - wb_reg_we in N+3
- A stall in cycle N makes cycle N+1's EX a bubble; the held instruction appears in EX one cycle later.
- A flush in cycle N makes EX and MEM bubbles in N+1. The instruction in EX/MEM during N still reaches WB in N+1.
- No combinational path from stall/flush to any output.

## Test plan
- Reset then controlSig=4'b1010, funct=100000, one edge -> ex_valid=1, ex_alu_ctrl=0010; mem_we=0 and mem_wb_pending=1 next cycle; wb_reg_we=1 the cycle after.
- Back-to-back sw (0001) then lw-style (0010) with stall=flush=0 -> mem_we pulses 1 then 0 in consecutive cycles; wb_reg_we follows one cycle behind the second.
- stall=1 for 2 cycles on bundle 1010 -> ex_valid=0 for 2 cycles while downstream drains; bubble_cnt=2.
- flush=1 and stall=1 together with EX/MEM holding WB=1 -> ex_valid=0, mem_we=0, mem_wb_pending=0 next cycle; wb_reg_we=1; bubble_cnt +1 only.
- ALUOp=10, funct=000000 -> ex_illegal=1 in EX cycle, err_sticky=1 next cycle and stays 1; ALUOp=11 behaves the same.
- Hold stall=1 for 300 cycles -> bubble_cnt saturates at 255. Then assert rst_n=0 mid-cycle -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/ctrl_bundle_pipe.sv
// Carries the 4-bit ID control bundle through ID/EX, EX/MEM and MEM/WB,
// decodes the ALU operation in EX, and inserts bubbles on stall/flush.
module ctrl_bundle_pipe #(
  parameter int BCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        controlSig,
  input  logic [5:0]        funct,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_ctrl,
  output logic              ex_illegal,
  output logic              mem_we,
  output logic              mem_wb_pending,
  output logic              wb_reg_we,
  output logic [BCNT_W-1:0] bubble_cnt,
  output logic              err_sticky
);

  localparam logic [BCNT_W-1:0] BCNT_MAX = {BCNT_W{1'b1}};
  localparam logic [BCNT_W-1:0] BCNT_ONE = {{(BCNT_W-1){1'b0}}, 1'b1};

  // 1111 marks an unsupported ALUOp/funct combination
  function automatic logic [3:0] alu_decode(input logic [1:0] aluop, input logic [5:0] fn);
    logic [3:0] ctrl;
    case (aluop)
      2'b00: ctrl = 4'b0010;
      2'b01: ctrl = 4'b0110;
      2'b10: begin
        case (fn)
          6'b100000: ctrl = 4'b0010;
          6'b100010: ctrl = 4'b0110;
          6'b100100: ctrl = 4'b0000;
          6'b100101: ctrl = 4'b0001;
          6'b101010: ctrl = 4'b0111;
          default:   ctrl = 4'b1111;
        endcase
      end
      default: ctrl = 4'b1111;
    endcase
    return ctrl;
  endfunction

  logic              idex_valid_q, idex_valid_d;
  logic [1:0]        idex_aluop_q, idex_aluop_d;
  logic              idex_wb_q, idex_wb_d;
  logic              idex_mem_q, idex_mem_d;
  logic [5:0]        idex_funct_q, idex_funct_d;
  logic              exmem_valid_q, exmem_valid_d;
  logic              exmem_wb_q, exmem_wb_d;
  logic              exmem_mem_q, exmem_mem_d;
  logic              memwb_valid_q, memwb_valid_d;
  logic              memwb_wb_q, memwb_wb_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              err_q, err_d;
  logic [3:0]        dec_s;

  // Stage next-state: flush bubbles ID/EX and EX/MEM, stall bubbles ID/EX only
  always_comb begin
    idex_valid_d  = 1'b0;
    idex_aluop_d  = 2'b00;
    idex_wb_d     = 1'b0;
    idex_mem_d    = 1'b0;
    idex_funct_d  = 6'b000000;
    exmem_valid_d = 1'b0;
    exmem_wb_d    = 1'b0;
    exmem_mem_d   = 1'b0;
    memwb_valid_d = exmem_valid_q;
    memwb_wb_d    = exmem_wb_q;
    if (stall || flush) begin
      idex_valid_d = 1'b0;
    end else begin
      idex_valid_d = 1'b1;
      idex_aluop_d = controlSig[3:2];
      idex_wb_d    = controlSig[1];
      idex_mem_d   = controlSig[0];
      idex_funct_d = funct;
    end
    if (flush) begin
      exmem_valid_d = 1'b0;
    end else begin
      exmem_valid_d = idex_valid_q;
      exmem_wb_d    = idex_wb_q;
      exmem_mem_d   = idex_mem_q;
    end
  end

  // Saturating bubble counter and sticky illegal-op flag
  always_comb begin
    bcnt_d = bcnt_q;
    if ((stall || flush) && (bcnt_q != BCNT_MAX)) begin
      bcnt_d = bcnt_q + BCNT_ONE;
    end else begin
      bcnt_d = bcnt_q;
    end
    err_d = err_q | ex_illegal;
  end

  // Pipeline state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid_q  <= 1'b0;
      idex_aluop_q  <= 2'b00;
      idex_wb_q     <= 1'b0;
      idex_mem_q    <= 1'b0;
      idex_funct_q  <= 6'b000000;
      exmem_valid_q <= 1'b0;
      exmem_wb_q    <= 1'b0;
      exmem_mem_q   <= 1'b0;
      memwb_valid_q <= 1'b0;
      memwb_wb_q    <= 1'b0;
      bcnt_q        <= {BCNT_W{1'b0}};
      err_q         <= 1'b0;
    end else begin
      idex_valid_q  <= idex_valid_d;
      idex_aluop_q  <= idex_aluop_d;
      idex_wb_q     <= idex_wb_d;
      idex_mem_q    <= idex_mem_d;
      idex_funct_q  <= idex_funct_d;
      exmem_valid_q <= exmem_valid_d;
      exmem_wb_q    <= exmem_wb_d;
      exmem_mem_q   <= exmem_mem_d;
      memwb_valid_q <= memwb_valid_d;
      memwb_wb_q    <= memwb_wb_d;
      bcnt_q        <= bcnt_d;
      err_q         <= err_d;
    end
  end

  // EX decode, forced to 0000 when EX holds a bubble
  always_comb begin
    dec_s = alu_decode(idex_aluop_q, idex_funct_q);
    if (idex_valid_q) begin
      ex_alu_ctrl = dec_s;
    end else begin
      ex_alu_ctrl = 4'b0000;
    end
  end

  assign ex_valid       = idex_valid_q;
  assign ex_illegal     = idex_valid_q & (ex_alu_ctrl == 4'b1111);
  assign mem_we         = exmem_valid_q & exmem_mem_q;
  assign mem_wb_pending = exmem_valid_q & exmem_wb_q;
  assign wb_reg_we      = memwb_valid_q & memwb_wb_q;
  assign bubble_cnt     = bcnt_q;
  assign err_sticky     = err_q;

endmodule
